// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter, per-channel trimmed duty,
// shadow registers that load on the last cycle of a period, optional center-aligned mode.
module pwm_multi #(
    parameter int CH   = 4,
    parameter int CW   = 8,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_en,
    input  logic          center,
    input  logic [CW-1:0] period_ini,
    input  logic [CW-1:0] period_min,
    input  logic [CW-1:0] period_max,
    input  logic          period_inc,
    input  logic          period_dec,
    input  logic [CW-1:0] duty_ini,
    input  logic [CW-1:0] duty_min,
    input  logic [CW-1:0] duty_max,
    input  logic [CH-1:0] inc,
    input  logic [CH-1:0] dec,
    output logic [CH-1:0] pwm,
    output logic          cycle_start
);

    localparam logic [CW:0] STEP_X = (CW+1)'(STEP);

    // Saturating trim at CW+1 bits; the upper clamp is applied last so max wins when min > max.
    function automatic logic [CW-1:0] trim(input logic [CW-1:0] cur, input logic [CW-1:0] lo,
                                           input logic [CW-1:0] hi, input logic up,
                                           input logic dn);
        logic [CW:0]   sum;
        logic [CW-1:0] r;
        r   = cur;
        sum = {1'b0, cur} + STEP_X;
        if (up && !dn) begin
            r = (sum > {1'b0, hi}) ? hi : sum[CW-1:0];
        end else if (dn && !up) begin
            r = ({1'b0, cur} < ({1'b0, lo} + STEP_X)) ? lo : cur - CW'(STEP);
            if (r > hi) r = hi;
        end
        return r;
    endfunction

    logic [CW-1:0] cnt;
    logic          down;
    logic          run;
    logic          center_act;
    logic [CW-1:0] period_act, period_pend, period_pend_nxt;
    logic [CW-1:0] duty_act [CH];
    logic [CW-1:0] duty_pend [CH];
    logic [CW-1:0] duty_pend_nxt [CH];
    logic [CH-1:0] inc_q, dec_q;
    logic          pinc_q, pdec_q;
    logic [CW-1:0] p_eff;
    logic          at_top;
    logic          wrap;
    logic [CH-1:0] cmp;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        p_eff  = (period_act < CW'(2)) ? CW'(2) : period_act;
        at_top = (cnt == p_eff - CW'(1));
        wrap   = center_act ? (down ? (cnt == CW'(1)) : (at_top && p_eff == CW'(2))) : at_top;
        period_pend_nxt = trim(period_pend, period_min, period_max,
                               period_inc & ~pinc_q, period_dec & ~pdec_q);
        for (int i = 0; i < CH; i++) begin
            duty_pend_nxt[i] = trim(duty_pend[i], duty_min, duty_max,
                                    inc[i] & ~inc_q[i], dec[i] & ~dec_q[i]);
            cmp[i]           = (cnt < duty_act[i]);
        end
    end

    // NOTE: state uses non-blocking assignments only; the duty arrays are reset explicitly
    // because they feed the outputs directly after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            down        <= 1'b0;
            run         <= 1'b0;
            center_act  <= 1'b0;
            period_act  <= period_ini;
            period_pend <= period_ini;
            for (int i = 0; i < CH; i++) begin
                duty_act[i]  <= duty_ini;
                duty_pend[i] <= duty_ini;
            end
            inc_q       <= '0;
            dec_q       <= '0;
            pinc_q      <= 1'b0;
            pdec_q      <= 1'b0;
            pwm         <= '0;
            cycle_start <= 1'b0;
        end else begin
            inc_q  <= inc;
            dec_q  <= dec;
            pinc_q <= period_inc;
            pdec_q <= period_dec;
            if (!pwm_en) begin
                cnt         <= '0;
                down        <= 1'b0;
                run         <= 1'b0;
                center_act  <= center;
                period_act  <= period_ini;
                period_pend <= period_ini;
                for (int i = 0; i < CH; i++) begin
                    duty_act[i]  <= duty_ini;
                    duty_pend[i] <= duty_ini;
                end
                pwm         <= '0;
                cycle_start <= 1'b0;
            end else begin
                run         <= 1'b1;
                pwm         <= run ? cmp : '0;
                cycle_start <= run && (cnt == '0);
                period_pend <= period_pend_nxt;
                for (int i = 0; i < CH; i++) duty_pend[i] <= duty_pend_nxt[i];
                // The first enabled edge only establishes cnt=0; counting starts after it.
                if (!run) begin
                    cnt  <= '0;
                    down <= 1'b0;
                end else if (wrap) begin
                    cnt        <= '0;
                    down       <= 1'b0;
                    center_act <= center;
                    period_act <= period_pend_nxt;
                    for (int i = 0; i < CH; i++) duty_act[i] <= duty_pend_nxt[i];
                end else if (center_act && !down && at_top) begin
                    down <= 1'b1;
                    cnt  <= cnt - CW'(1);
                end else if (down) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: expected period length and per-channel high counts
// are queued when stimulus is applied and compared against measured periods.
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_en;
    logic          center;
    logic [CW-1:0] period_ini, period_min, period_max;
    logic          period_inc, period_dec;
    logic [CW-1:0] duty_ini, duty_min, duty_max;
    logic [CH-1:0] inc, dec;
    logic [CH-1:0] pwm;
    logic          cycle_start;

    always #5 clk = ~clk;

    pwm_multi #(.CH(CH), .CW(CW), .STEP(1)) dut (
        .clk(clk), .rst(rst), .pwm_en(pwm_en), .center(center),
        .period_ini(period_ini), .period_min(period_min), .period_max(period_max),
        .period_inc(period_inc), .period_dec(period_dec),
        .duty_ini(duty_ini), .duty_min(duty_min), .duty_max(duty_max),
        .inc(inc), .dec(dec), .pwm(pwm), .cycle_start(cycle_start)
    );

    typedef struct {
        string tag;
        int    len;
        int    hi [CH];
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            m_len;
    int            m_hi [CH];
    bit            m_to;
    logic [CH-1:0] m_first;

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input int len, input int h0, input int h1,
                        input int h2, input int h3);
        exp_t e;
        e.tag   = tag;
        e.len   = len;
        e.hi[0] = h0;
        e.hi[1] = h1;
        e.hi[2] = h2;
        e.hi[3] = h3;
        sb.push_back(e);
    endtask

    // Measures one period from the current or next cycle_start up to (not including) the next.
    task automatic measure();
        int w;
        w    = 0;
        m_to = 1'b0;
        while (cycle_start !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) m_to = 1'b1;
        m_first = pwm;
        m_len   = 0;
        for (int i = 0; i < CH; i++) m_hi[i] = 0;
        if (!m_to) begin
            do begin
                for (int i = 0; i < CH; i++) m_hi[i] += (pwm[i] === 1'b1) ? 1 : 0;
                @(negedge clk);
                m_len++;
            end while (cycle_start !== 1'b1 && m_len < 1000);
            if (m_len >= 1000) m_to = 1'b1;
        end
    endtask

    task automatic score();
        exp_t e;
        measure();
        e = sb.pop_front();
        check({e.tag, " timeout"}, int'(m_to), 0);
        check({e.tag, " len"}, m_len, e.len);
        for (int i = 0; i < CH; i++)
            check($sformatf("%s hi%0d", e.tag, i), m_hi[i], e.hi[i]);
    endtask

    task automatic start_run(input string tag);
        pwm_en = 1'b1;
        @(negedge clk);
        check({tag, " cs first edge"}, int'(cycle_start), 0);
        @(negedge clk);
        check({tag, " cs second edge"}, int'(cycle_start), 1);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        pwm_en     = 1'b0;
        center     = 1'b0;
        period_ini = 8'd200;
        period_min = 8'd2;
        period_max = 8'd255;
        period_inc = 1'b0;
        period_dec = 1'b0;
        duty_ini   = 8'd60;
        duty_min   = 8'd0;
        duty_max   = 8'd255;
        inc        = '0;
        dec        = '0;
        #12;
        check("reset pwm", int'(pwm), 0);
        check("reset cs", int'(cycle_start), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_n(2);

        // 1: edge mode, 60 of 200
        start_run("t1");
        push("t1 p0", 200, 60, 60, 60, 60);
        score();
        check("t1 aligned rise", int'(m_first), 4'hf);
        push("t1 p1", 200, 60, 60, 60, 60);
        score();

        // 2: held inc counts once and waits for the boundary; then saturation at duty_max
        duty_max = 8'd70;
        inc[1]   = 1'b1;
        push("t2 hold cur", 200, 60, 60, 60, 60);
        score();
        for (int k = 0; k < 4; k++) begin
            push($sformatf("t2 hold p%0d", k), 200, 60, 61, 60, 60);
            score();
        end
        inc[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            inc[1] = 1'b1;
            @(negedge clk);
            inc[1] = 1'b0;
            @(negedge clk);
        end
        push("t2 sat", 200, 60, 70, 60, 60);
        score();

        // 3: dec to zero, then duty above period
        for (int k = 0; k < 70; k++) begin
            dec[0] = 1'b1;
            @(negedge clk);
            dec[0] = 1'b0;
            @(negedge clk);
        end
        push("t3 zero", 200, 0, 70, 60, 60);
        score();
        pwm_en = 1'b0;
        @(negedge clk);
        check("t3 dis pwm", int'(pwm), 0);
        check("t3 dis cs", int'(cycle_start), 0);
        duty_ini = 8'd250;
        wait_n(3);
        start_run("t3");
        push("t3 full", 200, 200, 200, 200, 200);
        score();

        // 4: center mode, mode change only at boundary
        pwm_en     = 1'b0;
        center     = 1'b1;
        period_ini = 8'd10;
        duty_ini   = 8'd3;
        wait_n(2);
        start_run("t4");
        push("t4 center", 18, 5, 5, 5, 5);
        score();
        check("t4 centred", int'(m_first), 4'hf);
        center = 1'b0;
        push("t4 still center", 18, 5, 5, 5, 5);
        score();
        push("t4 edge", 10, 3, 3, 3, 3);
        score();

        // 5: period trimming with clamp, simultaneous inc/dec
        pwm_en     = 1'b0;
        period_ini = 8'd200;
        duty_ini   = 8'd40;
        period_min = 8'd50;
        wait_n(2);
        start_run("t5");
        period_dec = 1'b1;
        push("t5 cur", 200, 40, 40, 40, 40);
        score();
        period_dec = 1'b0;
        push("t5 step", 199, 40, 40, 40, 40);
        score();
        for (int k = 0; k < 200; k++) begin
            period_dec = 1'b1;
            @(negedge clk);
            period_dec = 1'b0;
            @(negedge clk);
        end
        measure();
        push("t5 clamp", 50, 40, 40, 40, 40);
        score();
        inc[2] = 1'b1;
        dec[2] = 1'b1;
        @(negedge clk);
        inc[2] = 1'b0;
        dec[2] = 1'b0;
        push("t5 both", 50, 40, 40, 40, 40);
        score();

        // 6: async reset mid-period, then enable drop after trims
        wait_n(4);
        check("t6 pre-reset pwm", int'(pwm), 4'hf);
        period_ini = 8'd120;
        duty_ini   = 8'd25;
        rst        = 1'b1;
        #1;
        check("t6 async pwm", int'(pwm), 0);
        check("t6 async cs", int'(cycle_start), 0);
        @(negedge clk);
        rst = 1'b0;
        start_run("t6 rst");
        push("t6 after rst", 120, 25, 25, 25, 25);
        score();
        for (int k = 0; k < 3; k++) begin
            inc[0]     = 1'b1;
            period_inc = (k < 2);
            @(negedge clk);
            inc[0]     = 1'b0;
            period_inc = 1'b0;
            @(negedge clk);
        end
        push("t6 trimmed", 122, 28, 25, 25, 25);
        score();
        wait_n(3);
        pwm_en = 1'b0;
        @(negedge clk);
        check("t6 en drop pwm", int'(pwm), 0);
        wait_n(4);
        start_run("t6 reen");
        push("t6 reen", 120, 25, 25, 25, 25);
        score();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator. It is the parametrised successor of the team's single-channel period/duty PWM with inc/dec trimming. All CH channels share one period counter. Each channel has its own duty register, trimmed by edge-detected inc/dec requests and clamped to min/max limits. Period and duty updates use shadow registers that load only at the period boundary, so the outputs are glitch-free. An optional center-aligned mode is provided for motor/LED drive.

Parameters:
CH, 4, number of PWM channels
CW, 8, width of the period counter, period and duty values
STEP, 1, increment/decrement applied per inc/dec request (period and duty)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
pwm_en  input  1  run enable
center  input  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary
period_ini  input  CW  period loaded at reset and while disabled
period_min  input  CW  lower clamp for period trimming
period_max  input  CW  upper clamp for period trimming
period_inc  input  1  request period += STEP (rising-edge detected)
period_dec  input  1  request period -= STEP (rising-edge detected)
duty_ini  input  CW  duty loaded into every channel at reset and while disabled
duty_min  input  CW  lower clamp for duty trimming
duty_max  input  CW  upper clamp for duty trimming
inc  input  CH  per-channel duty += STEP request (rising-edge detected)
dec  input  CH  per-channel duty -= STEP request (rising-edge detected)
pwm  output  CH  PWM outputs, registered
cycle_start  output  1  one-cycle pulse on the first output cycle of each period, registered

Behaviour:
- Reset (async, rst=1):
  - cnt=0, direction=up.
  - period_act and period_pend = period_ini.
  - All duty_act and duty_pend = duty_ini.
  - pwm=0, cycle_start=0.
  - inc/dec edge-detect history cleared.
- Disabled (pwm_en=0):
  - cnt held at 0; pwm=0 and cycle_start=0 on the next edge.
  - pend and act registers reload from *_ini every cycle.
  - inc/dec requests are ignored.
- Effective period P:
  - P = max(period_act, 2).
- Edge mode counter:
  - cnt counts 0..P-1, then wraps to 0.
  - Period length is P cycles.
- Center mode counter:
  - cnt counts up 0..P-1, then down P-2..1, then back to 0.
  - Period length is 2P-2 cycles.
- Compare:
  - pwm[i] is registered from (cnt < duty_act[i]), so the output lags cnt by one cycle.
  - Edge mode: high for min(D,P) of P cycles.
  - Center mode: high for 2D-1 cycles when 1<=D<=P-1, centred on cnt=0.
  - D=0: constant low.
  - D>=P: constant high for the whole period.
- cycle_start: asserted together with the output cycle derived from cnt=0 at the start of a period.
- Run start:
  - The first edge with pwm_en=1 sets cnt=0 (period start).
  - pwm and cycle_start reflect that cycle one edge later.
- Trim requests:
  - A request is the rising edge of the input (a level held high counts once).
  - inc[i]: duty_pend[i] = min(duty_pend[i]+STEP, duty_max), computed at CW+1 bits, no wrap.
  - dec[i]: duty_pend[i] = max(duty_pend[i]-STEP, duty_min), with the underflow guard saturating at duty_min.
  - inc[i] and dec[i] rising in the same cycle: no change.
  - period_inc/period_dec follow the same rules against period_min/period_max.
- Shadow load:
  - On the last cycle of a period, act <= pend for the period, all duties and the center mode bit.
  - A request landing in that same cycle is included.
  - New values take effect from the next period start; a running period is never altered.
- Out-of-order limits:
  - If min > max, max wins.
  - ini outside [min,max] is accepted unclamped until the first trim.
- Reset mid-period: pwm drops to 0 asynchronously; all state returns to reset values.
- pwm_en falling mid-period: outputs go low the next edge. Re-enable restarts from cnt=0 with *_ini values.

Test Plan:
1. CH=4, CW=8, period_ini=200, duty_ini=60, edge mode, enable after reset -> every pwm high exactly 60 of each 200 cycles; cycle_start pulses every 200 cycles, aligned with pwm rise.
2. inc[1] held high for 1000 cycles mid-period -> ch1 duty 61 from the next period start only; other channels stay 60. Then 20 inc[1] pulses with duty_max=70 -> ch1 saturates at 70.
3. dec pulses with duty_min=0 until duty=0 -> ch0 constant low. duty_ini=250, period=200 -> constant high, no glitch at wrap.
4. center=1, period_ini=10, duty_ini=3 -> 18-cycle period, pwm high 5 cycles centred on cnt=0. center toggled mid-period -> mode changes only at the boundary.
5. period_dec pulses with period_min=50 from 200 -> period steps down one per pulse, each applied at a boundary, clamped at 50. inc[2] and dec[2] rising together -> duty unchanged.
6. rst pulsed mid-period -> pwm=0 immediately, registers back to ini. pwm_en dropped for 5 cycles after trims -> on re-enable duty back to duty_ini and period back to period_ini.
